// File: rtl/irq_vector_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_vector_ctrl_if
// Bundles the device-side request lines and the CPU-side vector-fetch
// handshake of the vectored interrupt controller.
//   irq_req  : level-sensitive device requests, bit 0 = highest priority
//   irq_vec  : packed device vectors, bits [16i+15:16i] belong to device i
//   irq_ack  : one-cycle acknowledge pulse to the served device
//   virq     : vectored interrupt request to the CPU
//   istb     : vector-fetch strobe from the CPU
//   iack     : vector-fetch acknowledge to the CPU
//   ivec     : interrupt vector presented to the CPU
// Modports: slave = the controller, master = CPU/device environment.
// ---------------------------------------------------------------------------
interface irq_vector_ctrl_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0]    irq_req;
    logic [16*N_IRQ-1:0] irq_vec;
    logic [N_IRQ-1:0]    irq_ack;
    logic                virq;
    logic                istb;
    logic                iack;
    logic [15:0]         ivec;

    modport slave (
        input  irq_req, irq_vec, istb,
        output irq_ack, virq, iack, ivec
    );

    modport master (
        output irq_req, irq_vec, istb,
        input  irq_ack, virq, iack, ivec
    );
endinterface

// File: rtl/irq_vector_ctrl.sv
// ---------------------------------------------------------------------------
// irq_vector_ctrl
// Fixed-priority vectored interrupt controller. Device requests are
// arbitrated (lowest index wins), a vectored request is raised to the CPU,
// and on the CPU's fetch strobe the winning device's vector is returned
// together with a one-cycle acknowledge pulse to that device.
// Ports:
//   wb_clk_i : clock, all state changes on its rising edge
//   wb_rst_i : asynchronous active-high reset
//   init_i   : synchronous bus INIT, overrides every other input
//   bus      : irq_vector_ctrl_if.slave (device requests + CPU handshake)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module irq_vector_ctrl #(
    parameter int          N_IRQ    = 4,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              init_i,
    irq_vector_ctrl_if.slave  bus
);
    localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic               virq_reg;
    logic               iack_reg;
    logic [N_IRQ-1:0]   irq_ack_reg;
    logic [15:0]        ivec_reg;

    // Per-device view of the packed vector bus and one-hot decodes.
    logic [15:0]        vec_arr [N_IRQ];
    logic [N_IRQ-1:0]   sel_onehot;
    logic [N_IRQ-1:0]   low_onehot;
    logic [SEL_W-1:0]   low_idx;
    logic               any_req;
    logic               sel_pending;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_dev
            assign vec_arr[gi]    = bus.irq_vec[16*gi +: 16];
            assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
            assign low_onehot[gi] = any_req && (low_idx == SEL_W'(gi));
        end
    endgenerate

    // Priority encoder: scanning downwards lets the lowest set index
    // overwrite any higher one, so index 0 wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (bus.irq_req[i]) begin
                low_idx = SEL_W'(i);
            end
        end
    end

    assign any_req     = |bus.irq_req;
    assign sel_pending = |(bus.irq_req & sel_onehot);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= S_IDLE;
            sel_reg     <= '0;
            virq_reg    <= 1'b0;
            iack_reg    <= 1'b0;
            irq_ack_reg <= '0;
            ivec_reg    <= SPUR_VEC;
        end else if (init_i) begin
            state_reg   <= S_IDLE;
            sel_reg     <= '0;
            virq_reg    <= 1'b0;
            iack_reg    <= 1'b0;
            irq_ack_reg <= '0;
            ivec_reg    <= SPUR_VEC;
        end else begin
            // The device acknowledge is a single-cycle pulse by default.
            irq_ack_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    virq_reg <= 1'b0;
                    iack_reg <= 1'b0;
                    if (bus.istb) begin
                        // Fetch with nothing requested: answer with the
                        // spurious vector and touch no device.
                        ivec_reg  <= SPUR_VEC;
                        iack_reg  <= 1'b1;
                        state_reg <= S_ACK;
                    end else if (any_req) begin
                        // virq rises one edge later, from inside REQ.
                        sel_reg   <= low_idx;
                        state_reg <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (bus.istb) begin
                        if (sel_pending) begin
                            ivec_reg    <= vec_arr[sel_reg];
                            irq_ack_reg <= sel_onehot;
                        end else if (any_req) begin
                            // Selected device dropped out; serve the best
                            // one still asking.
                            ivec_reg    <= vec_arr[low_idx];
                            irq_ack_reg <= low_onehot;
                            sel_reg     <= low_idx;
                        end else begin
                            ivec_reg    <= SPUR_VEC;
                        end
                        iack_reg  <= 1'b1;
                        virq_reg  <= 1'b0;
                        state_reg <= S_ACK;
                    end else if (!any_req) begin
                        virq_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        // Re-arbitrate every cycle so a higher-priority
                        // request can preempt before the fetch.
                        sel_reg  <= low_idx;
                        virq_reg <= 1'b1;
                    end
                end

                S_ACK: begin
                    virq_reg <= 1'b0;
                    if (!bus.istb) begin
                        iack_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    virq_reg  <= 1'b0;
                    iack_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.virq    = virq_reg;
    assign bus.iack    = iack_reg;
    assign bus.irq_ack = irq_ack_reg;
    assign bus.ivec    = ivec_reg;

endmodule
